// File: rtl/ddr4_v2_2_cal_rd_return_pkg.sv
// Shared types and helpers for the read-return tracker: entry layout, timestamp width
// and the per-rank latency-limit calculation.
package ddr4_v2_2_cal_rd_return_pkg;

  localparam int TS_W     = 8;
  localparam int RD_TAG_W = 8;

  typedef struct packed {
    logic [RD_TAG_W-1:0] tag;
    logic [1:0]          rank;
    logic                slot2;
    logic [TS_W-1:0]     ts;
  } rd_return_entry_t;

  // mCL is in tCK and a fabric cycle is 4 tCK, so round the latency up to whole cycles.
  function automatic logic [7:0] calc_lim(input logic [5:0] mcl,
                                          input int extra_cmd_delay,
                                          input int to_margin);
    int sum;
    sum = ((int'(mcl) + 3) >> 2) + extra_cmd_delay + to_margin + 2;
    return sum[7:0];
  endfunction

endpackage

// File: rtl/ddr4_v2_2_cal_rd_return_if.sv
// Bus between the read-CAS issue path / XiPhy and the read-return tracker.
interface ddr4_v2_2_cal_rd_return_if #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 8
);
    // Pulse semantics, no backpressure: rdCAS and rdDataVld are single-cycle events that the
    // tracker must accept in the cycle they are high; rtnVld is a one-cycle pulse and the
    // consumer must take rtnTag/rtnRank/rtnSlot2 in that same cycle.
    logic                   rdCAS;
    logic [1:0]             casSlot;
    logic [1:0]             winRank;
    logic [TAG_W-1:0]       rdTag;
    logic [5:0]             mCL0;
    logic [5:0]             mCL1;
    logic [5:0]             mCL2;
    logic [5:0]             mCL3;
    logic                   rdDataVld;
    logic                   errClr;
    logic                   rtnVld;
    logic [TAG_W-1:0]       rtnTag;
    logic [1:0]             rtnRank;
    logic                   rtnSlot2;
    logic [$clog2(DEPTH):0] outstanding;
    logic                   full;
    logic                   errOverflow;
    logic                   errUnexpected;
    logic                   errTimeout;

    modport master (
        output rdCAS, casSlot, winRank, rdTag, mCL0, mCL1, mCL2, mCL3, rdDataVld, errClr,
        input  rtnVld, rtnTag, rtnRank, rtnSlot2, outstanding, full,
               errOverflow, errUnexpected, errTimeout
    );

    modport slave (
        input  rdCAS, casSlot, winRank, rdTag, mCL0, mCL1, mCL2, mCL3, rdDataVld, errClr,
        output rtnVld, rtnTag, rtnRank, rtnSlot2, outstanding, full,
               errOverflow, errUnexpected, errTimeout
    );
endinterface

// File: rtl/ddr4_v2_2_cal_rd_return_fifo.sv
// Synchronous DEPTH-entry FIFO with an occupancy counter; head entry is read combinationally.
module ddr4_v2_2_cal_rd_return_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 19
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Status comes from the counter so a full FIFO never aliases to empty on pointer wrap.
    assign empty    = (count == '0);
    assign full     = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/ddr4_v2_2_cal_rd_return.sv
// Pairs issued read CASes in order with PHY read-data-valid pulses and tags each returned
// burst; flags overflow, unexpected data and reads that outlive their rank's latency limit.
module ddr4_v2_2_cal_rd_return
    import ddr4_v2_2_cal_rd_return_pkg::*;
#(
    parameter int DEPTH           = 16,
    parameter int TAG_W           = RD_TAG_W,
    parameter int EXTRA_CMD_DELAY = 0,
    parameter int TO_MARGIN       = 8
) (
    input logic                     clk,
    input logic                     rst,
    ddr4_v2_2_cal_rd_return_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = $bits(rd_return_entry_t);

    logic [TS_W-1:0]  now_q;
    logic [7:0]       lim_q [4];
    logic [5:0]       mcl [4];
    rd_return_entry_t push_ent;
    rd_return_entry_t head_ent;
    logic [ENT_W-1:0] head_bits;
    logic [CNT_W-1:0] count;
    logic             fifo_empty;
    logic             fifo_full;
    logic [TS_W-1:0]  head_age;
    logic             push;
    logic             data_pop;
    logic             timeout_pop;
    logic             set_ovf;
    logic             set_unx;

    logic             rtn_vld_q;
    logic [TAG_W-1:0] rtn_tag_q;
    logic [1:0]       rtn_rank_q;
    logic             rtn_slot2_q;
    logic             err_ovf_q;
    logic             err_unx_q;
    logic             err_to_q;
    logic             unused_slot_lsb;

    assign mcl[0] = bus.mCL0;
    assign mcl[1] = bus.mCL1;
    assign mcl[2] = bus.mCL2;
    assign mcl[3] = bus.mCL3;

    // Only slot 0 or 2 is ever issued, so bit 1 alone identifies the slot.
    assign unused_slot_lsb = bus.casSlot[0];

    assign push_ent = '{tag: bus.rdTag, rank: bus.winRank, slot2: bus.casSlot[1], ts: now_q};
    assign head_ent = head_bits;

    // Modular subtraction keeps the age correct across timestamp wrap.
    assign head_age    = now_q - head_ent.ts;
    assign data_pop    = bus.rdDataVld && !fifo_empty;
    assign timeout_pop = !fifo_empty && !bus.rdDataVld && (head_age > lim_q[head_ent.rank]);
    assign push        = bus.rdCAS && !fifo_full;
    assign set_ovf     = bus.rdCAS && fifo_full;
    assign set_unx     = bus.rdDataVld && fifo_empty;

    ddr4_v2_2_cal_rd_return_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_ent),
        .pop       (data_pop || timeout_pop),
        .pop_data  (head_bits),
        .count     (count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            now_q <= '0;
            for (int r = 0; r < 4; r++) lim_q[r] <= '0;
        end else begin
            now_q <= now_q + TS_W'(1);
            for (int r = 0; r < 4; r++) lim_q[r] <= calc_lim(mcl[r], EXTRA_CMD_DELAY, TO_MARGIN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rtn_vld_q   <= 1'b0;
            rtn_tag_q   <= '0;
            rtn_rank_q  <= '0;
            rtn_slot2_q <= 1'b0;
        end else begin
            rtn_vld_q <= data_pop;
            if (data_pop) begin
                rtn_tag_q   <= head_ent.tag;
                rtn_rank_q  <= head_ent.rank;
                rtn_slot2_q <= head_ent.slot2;
            end
        end
    end

    // Sticky flags: a new error in the same cycle as errClr still lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf_q <= 1'b0;
            err_unx_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            err_ovf_q <= set_ovf     || (err_ovf_q && !bus.errClr);
            err_unx_q <= set_unx     || (err_unx_q && !bus.errClr);
            err_to_q  <= timeout_pop || (err_to_q  && !bus.errClr);
        end
    end

    assign bus.rtnVld        = rtn_vld_q;
    assign bus.rtnTag        = rtn_tag_q;
    assign bus.rtnRank       = rtn_rank_q;
    assign bus.rtnSlot2      = rtn_slot2_q;
    assign bus.outstanding   = count;
    assign bus.full          = fifo_full;
    assign bus.errOverflow   = err_ovf_q;
    assign bus.errUnexpected = err_unx_q;
    assign bus.errTimeout    = err_to_q;
endmodule

// File: tb/tb_ddr4_v2_2_cal_rd_return.sv
// Bench for the read-return tracker: queue-based reference model of in-order pairing,
// age-based timeout and sticky error flags, with scenario tasks and random mixed traffic.
module tb_ddr4_v2_2_cal_rd_return;
  localparam int DEPTH  = 16;
  localparam int TAG_W  = 8;
  localparam int EXTRA  = 0;
  localparam int MARGIN = 8;

  typedef struct packed {
    logic [7:0] tag;
    logic [1:0] rank;
    logic       slot2;
    logic [7:0] ts;
  } ent_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ent_t        mq[$];
  logic [10:0] exp_q[$];
  int          m_now;
  int          m_lim[4];
  int          mcl_tb[4];
  logic        e_vld, e_ovf, e_unx, e_to;
  logic [10:0] exp_rtn;

  ddr4_v2_2_cal_rd_return_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  ddr4_v2_2_cal_rd_return #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .EXTRA_CMD_DELAY(EXTRA), .TO_MARGIN(MARGIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, evaluated at each rising edge with the inputs present at that edge.
  task automatic model_edge();
    bit was_full;
    bit s_ovf, s_unx, s_to;
    int age;
    if (rst) begin
      mq.delete(); exp_q.delete();
      m_now = 0; e_vld = 0; e_ovf = 0; e_unx = 0; e_to = 0;
      for (int r = 0; r < 4; r++) m_lim[r] = 0;
      return;
    end
    was_full = (mq.size() == DEPTH);
    s_ovf = 0; s_unx = 0; s_to = 0; e_vld = 0;
    if (bus.rdDataVld) begin
      if (mq.size() == 0) s_unx = 1;
      else begin
        exp_q.push_back({mq[0].tag, mq[0].rank, mq[0].slot2});
        void'(mq.pop_front());
        e_vld = 1;
      end
    end else if (mq.size() != 0) begin
      age = (m_now - int'(mq[0].ts) + 256) % 256;
      if (age > m_lim[mq[0].rank]) begin
        void'(mq.pop_front());
        s_to = 1;
      end
    end
    if (bus.rdCAS) begin
      if (was_full) s_ovf = 1;
      else mq.push_back('{tag: bus.rdTag, rank: bus.winRank, slot2: bus.casSlot[1], ts: m_now[7:0]});
    end
    e_ovf = s_ovf || (e_ovf && !bus.errClr);
    e_unx = s_unx || (e_unx && !bus.errClr);
    e_to  = s_to  || (e_to  && !bus.errClr);
    for (int r = 0; r < 4; r++) begin
      m_lim[r] = (mcl_tb[r] + 3) / 4 + EXTRA + MARGIN + 2;
      if (m_lim[r] > 127) begin
        errors++;
        $display("FAIL lim_rule rank %0d limit %0d exceeds 127", r, m_lim[r]);
      end
    end
    m_now = (m_now + 1) % 256;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    bus.rdCAS = 0; bus.rdDataVld = 0; bus.errClr = 0;
  endtask

  task automatic set_mcl(input int a, input int b, input int c, input int d);
    mcl_tb[0] = a; mcl_tb[1] = b; mcl_tb[2] = c; mcl_tb[3] = d;
    bus.mCL0 = 6'(a); bus.mCL1 = 6'(b); bus.mCL2 = 6'(c); bus.mCL3 = 6'(d);
    step(); step();
  endtask

  task automatic cas(input logic [7:0] tag, input logic [1:0] rank, input logic [1:0] slot);
    bus.rdCAS = 1; bus.rdTag = tag; bus.winRank = rank; bus.casSlot = slot;
  endtask

  task automatic clear_errs();
    bus.errClr = 1; step(); bus.errClr = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    repeat (3) step();
    checks++; if (bus.rtnVld !== 1'b0) begin errors++; $display("FAIL reset_rtnVld got %b want 0", bus.rtnVld); end
    checks++; if (bus.outstanding !== 5'd0) begin errors++; $display("FAIL reset_outstanding got %0d want 0", bus.outstanding); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.full); end
    checks++; if ({bus.errOverflow, bus.errUnexpected, bus.errTimeout} !== 3'b000) begin
      errors++; $display("FAIL reset_errs got %b%b%b want 000", bus.errOverflow, bus.errUnexpected, bus.errTimeout);
    end
    checks++; if ({bus.rtnTag, bus.rtnRank, bus.rtnSlot2} !== 11'd0) begin
      errors++; $display("FAIL reset_rtn_fields got %h want 0", {bus.rtnTag, bus.rtnRank, bus.rtnSlot2});
    end
    rst = 0;
  endtask

  task automatic test_single();
    set_mcl(16, 16, 16, 16);
    cas(8'h11, 2'd1, 2'd2); step(); idle();
    checks++; if (bus.outstanding !== 5'd1) begin errors++; $display("FAIL single_occ got %0d want 1", bus.outstanding); end
    repeat (3) step();
    bus.rdDataVld = 1; step(); idle();
    checks++; if (bus.rtnVld !== 1'b1) begin errors++; $display("FAIL single_rtnVld got %b want 1", bus.rtnVld); end
    checks++; if ({bus.rtnTag, bus.rtnRank, bus.rtnSlot2} !== {8'h11, 2'd1, 1'b1}) begin
      errors++; $display("FAIL single_fields got %h/%0d/%b want 11/1/1", bus.rtnTag, bus.rtnRank, bus.rtnSlot2);
    end
    checks++; if (bus.outstanding !== 5'd0) begin errors++; $display("FAIL single_occ_after got %0d want 0", bus.outstanding); end
    checks++; if ({bus.errOverflow, bus.errUnexpected, bus.errTimeout} !== 3'b000) begin
      errors++; $display("FAIL single_errs got %b%b%b want 000", bus.errOverflow, bus.errUnexpected, bus.errTimeout);
    end
    exp_q.delete();
    step();
    checks++; if (bus.rtnVld !== 1'b0) begin errors++; $display("FAIL single_pulse got %b want 0", bus.rtnVld); end
  endtask

  task automatic test_overflow();
    set_mcl(63, 63, 63, 63);
    for (int i = 0; i < 17; i++) begin
      cas(8'(i), 2'(i % 4), 2'd0); step();
      if (i == 15) begin
        checks++; if (bus.full !== 1'b1 || bus.outstanding !== 5'd16) begin
          errors++; $display("FAIL ovf_full got full=%b occ=%0d want 1/16", bus.full, bus.outstanding);
        end
        checks++; if (bus.errOverflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", bus.errOverflow); end
      end
    end
    idle();
    checks++; if (bus.errOverflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", bus.errOverflow); end
    checks++; if (bus.outstanding !== 5'd16) begin errors++; $display("FAIL ovf_occ got %0d want 16", bus.outstanding); end
    for (int i = 0; i < 16; i++) begin
      bus.rdDataVld = 1; step();
      checks++; if (bus.rtnVld !== 1'b1 || bus.rtnTag !== 8'(i)) begin
        errors++; $display("FAIL ovf_order got vld=%b tag=%0d want 1/%0d", bus.rtnVld, bus.rtnTag, i);
      end
    end
    idle(); exp_q.delete();
    step();
    checks++; if (bus.rtnVld !== 1'b0 || bus.outstanding !== 5'd0 || bus.full !== 1'b0) begin
      errors++; $display("FAIL ovf_drained got vld=%b occ=%0d full=%b want 0/0/0", bus.rtnVld, bus.outstanding, bus.full);
    end
    clear_errs();
    checks++; if (bus.errOverflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", bus.errOverflow); end
  endtask

  task automatic test_unexpected();
    bus.rdDataVld = 1; step(); idle();
    checks++; if (bus.errUnexpected !== 1'b1 || bus.rtnVld !== 1'b0) begin
      errors++; $display("FAIL unx_flag got unx=%b vld=%b want 1/0", bus.errUnexpected, bus.rtnVld);
    end
    clear_errs();
    checks++; if (bus.errUnexpected !== 1'b0) begin errors++; $display("FAIL unx_clr got %b want 0", bus.errUnexpected); end
    // Push into an empty FIFO alongside data: push lands, data is unexpected.
    cas(8'h3C, 2'd3, 2'd0); bus.rdDataVld = 1; step(); idle();
    checks++; if (bus.errUnexpected !== 1'b1 || bus.outstanding !== 5'd1 || bus.rtnVld !== 1'b0) begin
      errors++; $display("FAIL unx_push got unx=%b occ=%0d vld=%b want 1/1/0", bus.errUnexpected, bus.outstanding, bus.rtnVld);
    end
    // errClr and a fresh error in one cycle: set wins.
    bus.errClr = 1; bus.rdDataVld = 1; step(); idle();
    checks++; if (bus.rtnVld !== 1'b1 || bus.rtnTag !== 8'h3C || bus.errUnexpected !== 1'b0) begin
      errors++; $display("FAIL unx_pop got vld=%b tag=%h unx=%b want 1/3c/0", bus.rtnVld, bus.rtnTag, bus.errUnexpected);
    end
    exp_q.delete();
    bus.errClr = 1; bus.rdDataVld = 1; step(); idle();
    checks++; if (bus.errUnexpected !== 1'b1) begin errors++; $display("FAIL unx_set_wins got %b want 1", bus.errUnexpected); end
    clear_errs();
  endtask

  task automatic test_timeout();
    int hit;
    bit saw_vld;
    set_mcl(16, 16, 16, 16);
    hit = -1; saw_vld = 0;
    cas(8'h5A, 2'd0, 2'd0); step(); idle();
    for (int c = 1; c <= 20; c++) begin
      step();
      if (bus.errTimeout === 1'b1 && hit < 0) hit = c;
      if (bus.rtnVld === 1'b1) saw_vld = 1;
    end
    checks++; if (hit != 15) begin errors++; $display("FAIL to_cycle got %0d want 15", hit); end
    checks++; if (bus.outstanding !== 5'd0 || saw_vld) begin
      errors++; $display("FAIL to_removed got occ=%0d saw_vld=%b want 0/0", bus.outstanding, saw_vld);
    end
    checks++; if (bus.errTimeout !== e_to) begin errors++; $display("FAIL to_model got %b want %b", bus.errTimeout, e_to); end
    clear_errs();
  endtask

  task automatic test_back_to_back();
    set_mcl(63, 63, 63, 63);
    for (int i = 0; i < 3; i++) begin cas(8'(8'h20 + i), 2'(i), 2'd2); step(); end
    idle();
    checks++; if (bus.outstanding !== 5'd3) begin errors++; $display("FAIL b2b_occ3 got %0d want 3", bus.outstanding); end
    cas(8'h30, 2'd0, 2'd0); bus.rdDataVld = 1; step(); idle();
    checks++; if (bus.outstanding !== 5'd3 || bus.rtnVld !== 1'b1 || bus.rtnTag !== 8'h20) begin
      errors++; $display("FAIL b2b_same got occ=%0d vld=%b tag=%h want 3/1/20", bus.outstanding, bus.rtnVld, bus.rtnTag);
    end
    exp_q.delete();
    for (int n = 0; n < 40; n++) begin
      bus.rdCAS = ($urandom_range(0, 9) < 6);
      bus.rdTag = 8'($urandom_range(0, 255));
      bus.winRank = 2'($urandom_range(0, 3));
      bus.casSlot = $urandom_range(0, 1) ? 2'd2 : 2'd0;
      bus.rdDataVld = ($urandom_range(0, 9) < 5);
      step();
      checks++; if (bus.rtnVld !== e_vld) begin errors++; $display("FAIL b2b_vld op %0d got %b want %b", n, bus.rtnVld, e_vld); end
      if (bus.rtnVld === 1'b1) begin
        if (exp_q.size() == 0) exp_rtn = 11'h7FF;
        else exp_rtn = exp_q.pop_front();
        checks++; if ({bus.rtnTag, bus.rtnRank, bus.rtnSlot2} !== exp_rtn) begin
          errors++; $display("FAIL b2b_data op %0d got %h want %h", n, {bus.rtnTag, bus.rtnRank, bus.rtnSlot2}, exp_rtn);
        end
      end
      checks++; if (bus.outstanding !== 5'(mq.size())) begin
        errors++; $display("FAIL b2b_occ op %0d got %0d want %0d", n, bus.outstanding, mq.size());
      end
      checks++; if ({bus.errOverflow, bus.errUnexpected, bus.errTimeout} !== {e_ovf, e_unx, e_to}) begin
        errors++; $display("FAIL b2b_errs op %0d got %b%b%b want %b%b%b", n,
                           bus.errOverflow, bus.errUnexpected, bus.errTimeout, e_ovf, e_unx, e_to);
      end
    end
    idle();
  endtask

  task automatic test_ts_wrap();
    int guard;
    guard = 0;
    bus.rdDataVld = 1;
    while (mq.size() > 0 && guard < 40) begin step(); guard++; end
    idle(); exp_q.delete();
    clear_errs();
    set_mcl(16, 16, 16, 16);
    guard = 0;
    while (m_now != 250 && guard < 300) begin step(); guard++; end
    checks++; if (m_now != 250) begin errors++; $display("FAIL wrap_wait got now %0d want 250", m_now); end
    cas(8'h77, 2'd2, 2'd0); step(); idle();
    guard = 0;
    while (m_now != 4 && guard < 20) begin step(); guard++; end
    checks++; if (bus.errTimeout !== 1'b0 || bus.outstanding !== 5'd1) begin
      errors++; $display("FAIL wrap_pending got to=%b occ=%0d want 0/1", bus.errTimeout, bus.outstanding);
    end
    bus.rdDataVld = 1; step(); idle();
    checks++; if (bus.rtnVld !== 1'b1 || bus.rtnTag !== 8'h77 || bus.rtnRank !== 2'd2 || bus.errTimeout !== 1'b0) begin
      errors++; $display("FAIL wrap_return got vld=%b tag=%h rank=%0d to=%b want 1/77/2/0",
                         bus.rtnVld, bus.rtnTag, bus.rtnRank, bus.errTimeout);
    end
    exp_q.delete();
  endtask

  task automatic test_mid_reset();
    cas(8'h41, 2'd1, 2'd0); step();
    cas(8'h42, 2'd1, 2'd2); step(); idle();
    bus.rdDataVld = 1; rst = 1; step(); rst = 0; idle();
    checks++; if (bus.outstanding !== 5'd0 || bus.rtnVld !== 1'b0) begin
      errors++; $display("FAIL mrst_flush got occ=%0d vld=%b want 0/0", bus.outstanding, bus.rtnVld);
    end
    bus.rdDataVld = 1; step(); idle();
    checks++; if (bus.errUnexpected !== 1'b1 || bus.rtnVld !== 1'b0) begin
      errors++; $display("FAIL mrst_data got unx=%b vld=%b want 1/0", bus.errUnexpected, bus.rtnVld);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1;
    bus.rdCAS = 0; bus.casSlot = 0; bus.winRank = 0; bus.rdTag = 0;
    bus.rdDataVld = 0; bus.errClr = 0;
    mcl_tb[0] = 0; mcl_tb[1] = 0; mcl_tb[2] = 0; mcl_tb[3] = 0;
    bus.mCL0 = 0; bus.mCL1 = 0; bus.mCL2 = 0; bus.mCL3 = 0;
    test_reset();
    test_single();
    test_overflow();
    test_unexpected();
    test_timeout();
    test_back_to_back();
    test_ts_wrap();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
